// File: rtl/telemetry_ascii_framer.sv
// rtl/telemetry_ascii_framer.sv - snapshots HR/SpO2, converts to ASCII decimal, streams "HR:ddd,SP:ddd\r\n"
module telemetry_ascii_framer #(
    parameter int unsigned PERIOD_CYCLES = 50_000_000,
    parameter int unsigned HR_MAX        = 999,
    parameter int unsigned SPO2_MAX      = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_heart_rate,
    input  logic [7:0]  data_spo2,
    input  logic        start,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done
);
    localparam int unsigned TIMER_W    = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned TIMER_LAST = (PERIOD_CYCLES > 0) ? PERIOD_CYCLES - 1 : 0;
    localparam logic [9:0]  HR_SAT     = 10'(HR_MAX);
    localparam logic [9:0]  SP_SAT     = 10'(SPO2_MAX);
    localparam logic [3:0]  LAST_BYTE  = 4'd14;

    typedef enum logic [1:0] {IDLE, CONVERT, SEND, DONE} state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               tick;
    logic               trigger;
    logic [3:0]         byte_idx;
    logic [3:0]         next_idx;
    logic [3:0]         step_cnt;
    logic [21:0]        hr_dd;
    logic [21:0]        sp_dd;
    logic [9:0]         hr_sat;
    logic [9:0]         sp_sat;

    // One double-dabble iteration on {bcd[11:0], binary[9:0]}
    function automatic logic [21:0] dabble_step(input logic [21:0] s);
        logic [21:0] a;
        a = s;
        for (int n = 0; n < 3; n++) begin
            if (a[10+4*n +: 4] >= 4'd5) begin
                a[10+4*n +: 4] = a[10+4*n +: 4] + 4'd3;
            end
        end
        return {a[20:0], 1'b0};
    endfunction

    function automatic logic [7:0] frame_byte(input logic [3:0] i, input logic [11:0] h,
                                              input logic [11:0] s);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'h48;
            4'd1:    b = 8'h52;
            4'd2:    b = 8'h3A;
            4'd3:    b = {4'h3, h[11:8]};
            4'd4:    b = {4'h3, h[7:4]};
            4'd5:    b = {4'h3, h[3:0]};
            4'd6:    b = 8'h2C;
            4'd7:    b = 8'h53;
            4'd8:    b = 8'h50;
            4'd9:    b = 8'h3A;
            4'd10:   b = {4'h3, s[11:8]};
            4'd11:   b = {4'h3, s[7:4]};
            4'd12:   b = {4'h3, s[3:0]};
            4'd13:   b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    assign tick     = (PERIOD_CYCLES != 0) && (timer == TIMER_W'(TIMER_LAST));
    assign trigger  = start | tick;
    assign next_idx = byte_idx + 4'd1;

    always_comb begin
        hr_sat = (data_heart_rate > 16'(HR_MAX)) ? HR_SAT : data_heart_rate[9:0];
        sp_sat = ({2'b00, data_spo2} > SP_SAT) ? SP_SAT : {2'b00, data_spo2};
    end

    // Free-running trigger timer, independent of the frame state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else if (PERIOD_CYCLES != 0) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_idx   <= '0;
            step_cnt   <= '0;
            hr_dd      <= '0;
            sp_dd      <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        hr_dd    <= {12'd0, hr_sat};
                        sp_dd    <= {12'd0, sp_sat};
                        step_cnt <= '0;
                        byte_idx <= '0;
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    hr_dd    <= dabble_step(hr_dd);
                    sp_dd    <= dabble_step(sp_dd);
                    step_cnt <= step_cnt + 4'd1;
                    if (step_cnt == 4'd9) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    // First SEND cycle only presents byte 0; digits are final by then
                    if (!tx_valid) begin
                        tx_data  <= frame_byte(byte_idx, hr_dd[21:10], sp_dd[21:10]);
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        if (byte_idx == LAST_BYTE) begin
                            tx_valid   <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            byte_idx <= next_idx;
                            tx_data  <= frame_byte(next_idx, hr_dd[21:10], sp_dd[21:10]);
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_telemetry_ascii_framer.sv
// tb/tb_telemetry_ascii_framer.sv - self-checking bench for telemetry_ascii_framer
module tb_telemetry_ascii_framer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] hr;
    logic [7:0]  sp;
    logic        start;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;

    logic [15:0] hr_t;
    logic [7:0]  sp_t;
    logic        start_t;
    logic [7:0]  tx_data_t;
    logic        tx_valid_t;
    logic        tx_ready_t;
    logic        busy_t;
    logic        frame_done_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  rx[$];
    logic [7:0]  rx_t[$];
    logic [7:0]  exp_b[15];
    int          first_valid;
    int          done_at;
    int          done_cnt;
    int          stall_bad;
    int          busy_drop;

    always #5 clk = ~clk;

    telemetry_ascii_framer #(.PERIOD_CYCLES(0), .HR_MAX(999), .SPO2_MAX(100)) dut (
        .clk(clk), .rst_n(rst_n), .data_heart_rate(hr), .data_spo2(sp), .start(start),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .frame_done(frame_done)
    );

    telemetry_ascii_framer #(.PERIOD_CYCLES(100), .HR_MAX(999), .SPO2_MAX(100)) dut_t (
        .clk(clk), .rst_n(rst_n), .data_heart_rate(hr_t), .data_spo2(sp_t), .start(start_t),
        .tx_data(tx_data_t), .tx_valid(tx_valid_t), .tx_ready(tx_ready_t), .busy(busy_t),
        .frame_done(frame_done_t)
    );

    // Reference frame straight from the text format with decimal arithmetic
    task automatic build_exp(input int h, input int s);
        int hs;
        int ss;
        hs = (h > 999) ? 999 : h;
        ss = (s > 100) ? 100 : s;
        exp_b = '{8'h48, 8'h52, 8'h3A, 8'(48 + hs / 100), 8'(48 + (hs / 10) % 10), 8'(48 + hs % 10),
                  8'h2C, 8'h53, 8'h50, 8'h3A, 8'(48 + ss / 100), 8'(48 + (ss / 10) % 10),
                  8'(48 + ss % 10), 8'h0D, 8'h0A};
    endtask

    function automatic int frame_diff(input logic [7:0] q[$], input int base);
        int d;
        d = 0;
        if (q.size() < base + 15) return 15;
        for (int i = 0; i < 15; i++) begin
            if (q[base + i] !== exp_b[i]) d++;
        end
        return d;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Drives tx_ready (and optional retriggers) and records what the DUT hands over
    task automatic collect(input int mode, input bit retrig, input int post);
        bit         prev_stall;
        logic [7:0] prev_data;
        int         stretch;
        bit         did_long;
        prev_stall = 0; prev_data = 8'h00; stretch = 0; did_long = 0;
        rx.delete();
        first_valid = -1; done_at = -1; done_cnt = 0; stall_bad = 0; busy_drop = 0;
        for (int c = 1; c <= 1500; c++) begin
            @(posedge clk); #1;
            if (mode == 0) begin
                tx_ready = 1'b1;
            end else if (stretch > 0) begin
                tx_ready = 1'b0;
                stretch--;
            end else if ((!did_long && c >= 14) || $urandom_range(0, 15) == 0) begin
                tx_ready = 1'b0;
                stretch = 19;
                did_long = 1;
            end else begin
                tx_ready = 1'($urandom_range(0, 1));
            end
            if (retrig) begin
                start = (c == 3 || c == 5 || c == 20);
                if (c == 4) hr = 16'd321;
            end
            @(negedge clk);
            if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_bad++;
            if (done_cnt == 0 && busy !== 1'b1) busy_drop++;
            if (tx_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (frame_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) rx.push_back(tx_data);
            prev_stall = (tx_valid === 1'b1) && !tx_ready;
            prev_data = tx_data;
            if (done_cnt > 0 && c >= done_at + post) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got valid=%b busy=%b, required 0/0", tx_valid, busy); end
    endtask

    task automatic test_basic();
        hr = 16'd75; sp = 8'd98;
        build_exp(75, 98);
        pulse_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_set: got %b, required 1", busy); end
        collect(0, 0, 3);
        n_checks++; if (frame_diff(rx, 0) !== 0) begin n_fail++; $display("FAIL basic_frame: got %0d bad bytes of %0d, required 0", frame_diff(rx, 0), rx.size()); end
        n_checks++; if (rx.size() !== 15) begin n_fail++; $display("FAIL basic_count: got %0d bytes, required 15", rx.size()); end
        n_checks++; if (first_valid !== 11) begin n_fail++; $display("FAIL basic_first_valid: got %0d, required 11", first_valid); end
        n_checks++; if (done_at !== 26) begin n_fail++; $display("FAIL basic_done_at: got %0d, required 26", done_at); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d, required 1", done_cnt); end
        n_checks++; if (busy_drop !== 0) begin n_fail++; $display("FAIL basic_busy_hold: got %0d low cycles, required 0", busy_drop); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_clear: got %b, required 0", busy); end
    endtask

    task automatic test_values();
        int th[5] = '{125, 1234, 0, 999, 1000};
        int ts[5] = '{80, 200, 0, 100, 101};
        int h;
        int s;
        for (int n = 0; n < 11; n++) begin
            if (n < 5) begin
                h = th[n]; s = ts[n];
            end else begin
                h = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 999)) : int'($urandom_range(1000, 65535));
                s = int'($urandom_range(0, 255));
            end
            hr = 16'(h); sp = 8'(s);
            build_exp(h, s);
            pulse_start();
            collect(0, 0, 2);
            n_checks++; if (frame_diff(rx, 0) !== 0 || rx.size() !== 15) begin n_fail++; $display("FAIL values_frame hr=%0d sp=%0d: got %0d bad bytes of %0d, required 0 of 15", h, s, frame_diff(rx, 0), rx.size()); end
        end
    endtask

    task automatic test_backpressure();
        int h;
        int s;
        for (int n = 0; n < 3; n++) begin
            h = int'($urandom_range(0, 1200));
            s = int'($urandom_range(0, 255));
            hr = 16'(h); sp = 8'(s);
            build_exp(h, s);
            pulse_start();
            collect(1, 0, 2);
            n_checks++; if (frame_diff(rx, 0) !== 0 || rx.size() !== 15) begin n_fail++; $display("FAIL bp_frame: got %0d bad bytes of %0d, required 0 of 15", frame_diff(rx, 0), rx.size()); end
            n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d unstable stalls, required 0", stall_bad); end
            n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d, required 1", done_cnt); end
        end
    endtask

    task automatic test_retrigger();
        hr = 16'd88; sp = 8'd97;
        build_exp(88, 97);
        pulse_start();
        collect(0, 1, 40);
        n_checks++; if (frame_diff(rx, 0) !== 0) begin n_fail++; $display("FAIL retrig_frame: got %0d bad bytes, required 0", frame_diff(rx, 0)); end
        n_checks++; if (rx.size() !== 15) begin n_fail++; $display("FAIL retrig_count: got %0d bytes, required 15", rx.size()); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL retrig_done_pulses: got %0d, required 1", done_cnt); end
        n_checks++; if (busy_drop !== 0) begin n_fail++; $display("FAIL retrig_busy_hold: got %0d low cycles, required 0", busy_drop); end
    endtask

    task automatic test_reset_mid();
        hr = 16'd456; sp = 8'd91;
        tx_ready = 1'b1;
        pulse_start();
        repeat (17) @(posedge clk);
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h2C) begin n_fail++; $display("FAIL rstmid_pending: got valid=%b data=%h, required 1/2c", tx_valid, tx_data); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_valid: got %b, required 0", tx_valid); end
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_after: got valid=%b data=%h busy=%b done=%b, required 0/00/0/0", tx_valid, tx_data, busy, frame_done);
        end
        hr = 16'd42; sp = 8'd95;
        build_exp(42, 95);
        pulse_start();
        collect(0, 0, 2);
        n_checks++; if (frame_diff(rx, 0) !== 0 || rx.size() !== 15) begin n_fail++; $display("FAIL rstmid_new_frame: got %0d bad bytes of %0d, required 0 of 15", frame_diff(rx, 0), rx.size()); end
        n_checks++; if (first_valid !== 11) begin n_fail++; $display("FAIL rstmid_first_valid: got %0d, required 11", first_valid); end
    endtask

    task automatic test_timer();
        int starts[$];
        bit pv;
        int dones_mid;
        int gap_req[4] = '{100, 100, 200, 100};
        hr_t = 16'd2000; sp_t = 8'd99;
        tx_ready_t = 1'b1; start_t = 1'b0;
        build_exp(2000, 99);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (busy_t === 1'b0) break;
        end
        rx_t.delete();
        pv = 0; dones_mid = 0;
        for (int c = 0; c < 1500 && starts.size() < 5; c++) begin
            @(posedge clk); #1;
            start_t = (starts.size() == 2 && c == starts[1] + 88);
            tx_ready_t = !(starts.size() >= 3 && c > starts[2] && c <= starts[2] + 150);
            @(negedge clk);
            if (tx_valid_t === 1'b1 && !pv) starts.push_back(c);
            pv = (tx_valid_t === 1'b1);
            if (tx_valid_t === 1'b1 && tx_ready_t === 1'b1) rx_t.push_back(tx_data_t);
            if (frame_done_t === 1'b1 && starts.size() == 2) dones_mid++;
        end
        start_t = 1'b0; tx_ready_t = 1'b1;
        n_checks++;
        if (starts.size() !== 5) begin
            n_fail++; $display("FAIL timer_frames: got %0d frame starts, required 5", starts.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (starts[i+1] - starts[i] !== gap_req[i]) begin n_fail++; $display("FAIL timer_gap%0d: got %0d, required %0d", i, starts[i+1] - starts[i], gap_req[i]); end
            end
        end
        n_checks++; if (dones_mid !== 1) begin n_fail++; $display("FAIL timer_coincident: got %0d frames, required 1", dones_mid); end
        for (int f = 0; f < 4; f++) begin
            n_checks++; if (frame_diff(rx_t, 15 * f) !== 0) begin n_fail++; $display("FAIL timer_frame%0d: got %0d bad bytes, required 0", f, frame_diff(rx_t, 15 * f)); end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; hr = '0; sp = '0; tx_ready = 1'b1;
        start_t = 1'b0; hr_t = '0; sp_t = '0; tx_ready_t = 1'b1;
        test_reset();
        test_basic();
        test_values();
        test_backpressure();
        test_retrigger();
        test_reset_mid();
        test_timer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
